feed_sequencer_multi: RTL and testbench

- Parametrised successor of the engine-side system manager FSM. Runs the fetch→bot→dump-check cycle across NUM_FEEDS independent upstream feeds in round-robin order.
- Each feed keeps its own last-acknowledged index; fetches retry on timeout.
- Dump requests from NUM_DUMP_SRC sources are merged into a sticky pending flag.
- Sits in the 200 MHz engine domain between the CDC'd RX/ACK signals and order_book_top.

---
 rtl/feed_seq_pkg.sv | 24 ++
 rtl/feed_index_table.sv | 38 +++
 rtl/feed_sequencer_multi.sv | 203 ++++++++++++++++++++
 tb/tb_feed_sequencer_multi.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/feed_seq_pkg.sv
// Shared state encodings and width helpers for the multi-feed engine sequencer.
package feed_seq_pkg;

   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      ST_FETCH      = 3'd0,
      ST_SEND_ACK   = 3'd1,
      ST_WAIT_DATA  = 3'd2,
      ST_BOT        = 3'd3,
      ST_DUMP_CHECK = 3'd4,
      ST_DUMPING    = 3'd5
   } state_t;

   // clog2 that never returns less than one bit.
   function automatic int clog2_min1(input int v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/feed_index_table.sv
// Per-feed last-acknowledged index storage: one write port, one combinational read port.
module feed_index_table
   import feed_seq_pkg::*;
#(
   parameter int NUM_FEEDS = 4,
   parameter int FEED_W    = 2,
   parameter int IDX_W     = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [FEED_W-1:0] wr_feed,
   input  logic [IDX_W-1:0]  wr_index,
   input  logic [FEED_W-1:0] rd_feed,
   output logic [IDX_W-1:0]  rd_index
);

   logic [IDX_W-1:0] entries [NUM_FEEDS];

   // Feed ids beyond NUM_FEEDS-1 (non power-of-two counts) are dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int f = 0; f < NUM_FEEDS; f++) entries[f] <= '0;
      end else if (wr_en) begin
         for (int f = 0; f < NUM_FEEDS; f++) begin
            if (wr_feed == FEED_W'(f)) entries[f] <= wr_index;
         end
      end
   end

   always_comb begin
      rd_index = '0;
      for (int f = 0; f < NUM_FEEDS; f++) begin
         if (rd_feed == FEED_W'(f)) rd_index = entries[f];
      end
   end

endmodule

// File: rtl/feed_sequencer_multi.sv
// Round-robin fetch -> bot -> dump-check sequencer over NUM_FEEDS upstream feeds.
// Optional FEED_SEQ_STATS_EN adds the 48-bit o_stats counter port.
module feed_sequencer_multi
   import feed_seq_pkg::*;
#(
   parameter int NUM_FEEDS     = 4,
   parameter int FEED_W        = 2,
   parameter int IDX_W         = 12,
   parameter int NUM_DUMP_SRC  = 2,
   parameter int FETCH_TIMEOUT = 10000,
   parameter int ACK_TIMEOUT   = 1000,
   parameter int MAX_RETRY     = 2,
   parameter int BOT_CYCLES    = 5000,
   parameter int DUMP_GUARD    = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_rx_tlast_pulse,
   input  logic [IDX_W-1:0]        i_rx_index,
   input  logic [FEED_W-1:0]       i_rx_feed_id,
   input  logic                    i_ack_done,
   input  logic [NUM_DUMP_SRC-1:0] i_dump_req,
   input  logic                    i_engine_busy,
   output logic                    o_ack_start,
   output logic [FEED_W-1:0]       o_ack_feed,
   output logic [IDX_W-1:0]        o_ack_index,
   output logic                    o_enable_rx,
   output logic                    o_enable_bot,
   output logic                    o_enable_tx,
   output logic                    o_start_dump,
   output logic                    o_dump_pending,
   output logic                    o_fetch_fail,
`ifdef FEED_SEQ_STATS_EN
   output logic [47:0]             o_stats,
`endif
   output logic [STATE_W-1:0]      o_state
);

   localparam int MAX_LIMIT = max2(max2(FETCH_TIMEOUT, ACK_TIMEOUT), max2(BOT_CYCLES, DUMP_GUARD));
   localparam int TMR_W     = clog2_min1(MAX_LIMIT) + 1;
   localparam int RETRY_W   = clog2_min1(MAX_RETRY + 1);

   // Limits are expressed as the timer value on the last cycle of the state.
   localparam logic [TMR_W-1:0] FETCH_LAST = TMR_W'(FETCH_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] ACK_LAST   = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] BOT_LAST   = TMR_W'(BOT_CYCLES - 1);
   localparam logic [TMR_W-1:0] GUARD_LAST = TMR_W'(DUMP_GUARD - 1);

   state_t              state;
   logic [FEED_W-1:0]   ptr;
   logic [TMR_W-1:0]    timer;
   logic [RETRY_W-1:0]  retry;
   logic                pending;
   logic                start_dump;
   logic                fetch_fail;
   logic [IDX_W-1:0]    ptr_index;
   logic                rx_wr;
   logic                rx_match;
   logic                dump_set;

`ifdef FEED_SEQ_STATS_EN
   logic [15:0] fail_cnt;
   logic [15:0] retry_cnt;
   logic [15:0] dump_cnt;
`endif

   function automatic logic [TMR_W-1:0] sat_inc_tmr(input logic [TMR_W-1:0] t);
      return (t == {TMR_W{1'b1}}) ? t : t + TMR_W'(1);
   endfunction

   function automatic logic [15:0] sat_inc16(input logic [15:0] c);
      return (c == 16'hFFFF) ? c : c + 16'd1;
   endfunction

   assign dump_set = |i_dump_req;
   assign rx_wr    = i_rx_tlast_pulse && (state == ST_WAIT_DATA);
   assign rx_match = rx_wr && (i_rx_feed_id == ptr);

   feed_index_table #(
      .NUM_FEEDS (NUM_FEEDS),
      .FEED_W    (FEED_W),
      .IDX_W     (IDX_W)
   ) u_index_table (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (rx_wr),
      .wr_feed  (i_rx_feed_id),
      .wr_index (i_rx_index),
      .rd_feed  (ptr),
      .rd_index (ptr_index)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_FETCH;
         ptr        <= '0;
         timer      <= '0;
         retry      <= '0;
         pending    <= 1'b0;
         start_dump <= 1'b0;
         fetch_fail <= 1'b0;
`ifdef FEED_SEQ_STATS_EN
         fail_cnt   <= '0;
         retry_cnt  <= '0;
         dump_cnt   <= '0;
`endif
      end else begin
         start_dump <= 1'b0;
         fetch_fail <= 1'b0;
         timer      <= sat_inc_tmr(timer);
         pending    <= pending | dump_set;
         case (state)
            ST_FETCH: begin
               state <= ST_SEND_ACK;
               timer <= '0;
            end
            ST_SEND_ACK: begin
               if (i_ack_done) begin
                  state <= ST_WAIT_DATA;
                  timer <= '0;
               end else if (timer >= ACK_LAST) begin
                  state      <= ST_BOT;
                  timer      <= '0;
                  fetch_fail <= 1'b1;
`ifdef FEED_SEQ_STATS_EN
                  fail_cnt   <= sat_inc16(fail_cnt);
`endif
               end
            end
            ST_WAIT_DATA: begin
               // A matching packet beats a timeout landing in the same cycle.
               if (rx_match) begin
                  state <= ST_BOT;
                  timer <= '0;
               end else if (timer >= FETCH_LAST) begin
                  timer <= '0;
                  if (retry < RETRY_W'(MAX_RETRY)) begin
                     state     <= ST_SEND_ACK;
                     retry     <= retry + RETRY_W'(1);
`ifdef FEED_SEQ_STATS_EN
                     retry_cnt <= sat_inc16(retry_cnt);
`endif
                  end else begin
                     state      <= ST_BOT;
                     fetch_fail <= 1'b1;
`ifdef FEED_SEQ_STATS_EN
                     fail_cnt   <= sat_inc16(fail_cnt);
`endif
                  end
               end
            end
            ST_BOT: begin
               if (timer >= BOT_LAST) begin
                  state <= ST_DUMP_CHECK;
                  timer <= '0;
               end
            end
            ST_DUMP_CHECK: begin
               ptr   <= (ptr == FEED_W'(NUM_FEEDS - 1)) ? '0 : ptr + FEED_W'(1);
               timer <= '0;
               if (pending) begin
                  state      <= ST_DUMPING;
                  start_dump <= 1'b1;
                  pending    <= dump_set;
`ifdef FEED_SEQ_STATS_EN
                  dump_cnt   <= sat_inc16(dump_cnt);
`endif
               end else begin
                  state <= ST_FETCH;
                  retry <= '0;
               end
            end
            ST_DUMPING: begin
               if ((timer >= GUARD_LAST) && !i_engine_busy) begin
                  state <= ST_FETCH;
                  timer <= '0;
                  retry <= '0;
               end
            end
            default: begin
               state <= ST_FETCH;
               timer <= '0;
            end
         endcase
      end
   end

   assign o_ack_start    = (state == ST_SEND_ACK);
   assign o_ack_feed     = ptr;
   assign o_ack_index    = ptr_index;
   assign o_enable_rx    = (state == ST_WAIT_DATA);
   assign o_enable_bot   = (state == ST_BOT);
   assign o_enable_tx    = (state == ST_BOT) || (state == ST_DUMP_CHECK);
   assign o_start_dump   = start_dump;
   assign o_dump_pending = pending;
   assign o_fetch_fail   = fetch_fail;
   assign o_state        = state;

`ifdef FEED_SEQ_STATS_EN
   assign o_stats = {fail_cnt, retry_cnt, dump_cnt};
`endif

endmodule

// File: tb/tb_feed_sequencer_multi.sv
// Directed bench for feed_sequencer_multi with shortened timeouts.
module tb_feed_sequencer_multi;

   localparam int NF    = 4;
   localparam int FW    = 2;
   localparam int IW    = 12;
   localparam int ND    = 2;
   localparam int FT    = 12;
   localparam int AT    = 6;
   localparam int MR    = 2;
   localparam int BC    = 5;
   localparam int DG    = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          i_rx_tlast_pulse = 1'b0;
   logic [IW-1:0] i_rx_index = '0;
   logic [FW-1:0] i_rx_feed_id = '0;
   logic          i_ack_done = 1'b0;
   logic [ND-1:0] i_dump_req = '0;
   logic          i_engine_busy = 1'b0;
   logic          o_ack_start;
   logic [FW-1:0] o_ack_feed;
   logic [IW-1:0] o_ack_index;
   logic          o_enable_rx;
   logic          o_enable_bot;
   logic          o_enable_tx;
   logic          o_start_dump;
   logic          o_dump_pending;
   logic          o_fetch_fail;
   logic [2:0]    o_state;

   int checks = 0;
   int errors = 0;
   int ack_entries = 0;
   int fail_pulses = 0;
   int dump_pulses = 0;
   int entries_snap;
   logic ack_prev = 1'b0;

   feed_sequencer_multi #(
      .NUM_FEEDS     (NF),
      .FEED_W        (FW),
      .IDX_W         (IW),
      .NUM_DUMP_SRC  (ND),
      .FETCH_TIMEOUT (FT),
      .ACK_TIMEOUT   (AT),
      .MAX_RETRY     (MR),
      .BOT_CYCLES    (BC),
      .DUMP_GUARD    (DG)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .i_rx_tlast_pulse (i_rx_tlast_pulse),
      .i_rx_index       (i_rx_index),
      .i_rx_feed_id     (i_rx_feed_id),
      .i_ack_done       (i_ack_done),
      .i_dump_req       (i_dump_req),
      .i_engine_busy    (i_engine_busy),
      .o_ack_start      (o_ack_start),
      .o_ack_feed       (o_ack_feed),
      .o_ack_index      (o_ack_index),
      .o_enable_rx      (o_enable_rx),
      .o_enable_bot     (o_enable_bot),
      .o_enable_tx      (o_enable_tx),
      .o_start_dump     (o_start_dump),
      .o_dump_pending   (o_dump_pending),
      .o_fetch_fail     (o_fetch_fail),
      .o_state          (o_state)
   );

   always #5 clk = ~clk;

   // Pulse and SEND_ACK-entry counters, sampled mid-cycle.
   always @(negedge clk) begin
      if (o_ack_start && !ack_prev) ack_entries++;
      ack_prev = o_ack_start;
      if (o_fetch_fail) fail_pulses++;
      if (o_start_dump) dump_pulses++;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Steps until o_state reaches s, then checks the number of cycles taken.
   task automatic wait_state(input string tag, input logic [2:0] s, input int exp_n);
      int n = 0;
      while (o_state !== s && n < 200) begin
         step();
         n++;
      end
      chk(tag, n, exp_n);
   endtask

   function automatic logic [23:0] all_outs();
      return {o_ack_start, o_enable_rx, o_enable_bot, o_enable_tx, o_start_dump,
              o_dump_pending, o_fetch_fail, o_state, o_ack_feed, o_ack_index};
   endfunction

   task automatic rx_pulse(input logic [FW-1:0] feed, input logic [IW-1:0] idx);
      i_rx_tlast_pulse = 1'b1;
      i_rx_feed_id     = feed;
      i_rx_index       = idx;
      step();
      i_rx_tlast_pulse = 1'b0;
   endtask

   task automatic ack_now();
      i_ack_done = 1'b1;
      step();
      i_ack_done = 1'b0;
   endtask

   initial begin
      // Reset held
      step(); step(); step();
      chk("reset_outs", 32'(all_outs()), 32'h0);
      rst_n = 1'b1;
      chk("fetch_after_release", 32'(o_state), 32'd0);

      // Turn 0 (feed 0): ACK, matching reply
      step();
      chk("t0_send_ack_state", 32'(o_state), 32'd1);
      chk("t0_ack_start", 32'(o_ack_start), 32'd1);
      chk("t0_ack_feed_idx", {o_ack_feed, o_ack_index}, 32'h0);
      ack_now();
      chk("t0_wait_rx", {29'd0, o_state}, 32'd2);
      chk("t0_enable_rx", 32'(o_enable_rx), 32'd1);
      rx_pulse(2'd0, 12'h0AB);
      chk("t0_bot_outs", {o_enable_bot, o_enable_tx, o_fetch_fail, o_state}, {3'b110, 3'd3});
      wait_state("t0_bot_dwell", 3'd4, BC);
      chk("t0_dc_outs", {o_enable_tx, o_enable_bot, o_start_dump}, 32'b100);
      wait_state("t0_to_send_ack", 3'd1, 2);
      chk("t1_ack_feed", 32'(o_ack_feed), 32'd1);
      chk("t1_ack_index", 32'(o_ack_index), 32'h000);

      // Turn 1 (feed 1): reply 0x123
      ack_now();
      rx_pulse(2'd1, 12'h123);
      chk("t1_bot", 32'(o_state), 32'd3);
      entries_snap = ack_entries;
      wait_state("t1_to_send_ack", 3'd1, BC + 2);
      chk("t2_ack_feed_idx", {o_ack_feed, o_ack_index}, {2'd2, 12'h000});

      // Turn 2 (feed 2): foreign packet, then no reply -> retries and fail
      ack_now();
      rx_pulse(2'd0, 12'hFFF);
      chk("t2_foreign_stays_wait", 32'(o_state), 32'd2);
      wait_state("t2_first_timeout", 3'd1, FT - 1);
      ack_now();
      wait_state("t2_retry1_timeout", 3'd1, FT);
      ack_now();
      wait_state("t2_retry2_to_bot", 3'd3, FT);
      chk("t2_fetch_fail_pulse", 32'(o_fetch_fail), 32'd1);
      i_dump_req    = 2'b10;
      i_engine_busy = 1'b1;
      step();
      i_dump_req = 2'b00;
      chk("t2_ack_entries", ack_entries - entries_snap, 32'd3);
      chk("t2_fail_single_cycle", 32'(o_fetch_fail), 32'd0);
      chk("t2_pending_set", 32'(o_dump_pending), 32'd1);
      wait_state("t2_bot_rest", 3'd4, BC - 1);
      chk("t2_dc_no_pulse_yet", {o_start_dump, o_dump_pending}, 32'b01);
      step();
      chk("t2_dumping", {o_start_dump, o_dump_pending, o_state}, {2'b10, 3'd5});
      for (int i = 0; i < 20; i++) step();
      chk("t2_busy_holds", 32'(o_state), 32'd5);
      i_engine_busy = 1'b0;
      step();
      chk("t2_dump_exit", 32'(o_state), 32'd0);
      chk("t2_counts", {fail_pulses[15:0], dump_pulses[15:0]}, {16'd1, 16'd1});
      step();

      // Turn 3 (feed 3): ACK never completes; collision at DUMP_CHECK clear
      chk("t3_ack_feed_idx", {o_ack_feed, o_ack_index, o_ack_start}, {2'd3, 12'h000, 1'b1});
      wait_state("t3_ack_timeout", 3'd3, AT);
      chk("t3_fetch_fail", 32'(o_fetch_fail), 32'd1);
      i_dump_req = 2'b01;
      step();
      i_dump_req = 2'b00;
      wait_state("t3_bot_rest", 3'd4, BC - 1);
      i_dump_req = 2'b01;
      step();
      i_dump_req = 2'b00;
      chk("t3_collision_keeps_pending", {o_start_dump, o_dump_pending, o_state}, {2'b11, 3'd5});
      wait_state("t3_dump_guard", 3'd0, DG);
      step();

      // Turn 4 (feed 0, wrapped): sees 0xFFF, index wraps to 0, second dump
      chk("t4_ack_feed_idx", {o_ack_feed, o_ack_index}, {2'd0, 12'hFFF});
      ack_now();
      rx_pulse(2'd0, 12'h000);
      wait_state("t4_bot_dwell", 3'd4, BC);
      step();
      chk("t4_second_dump", {o_start_dump, o_dump_pending, o_state}, {2'b10, 3'd5});
      wait_state("t4_dump_guard", 3'd0, DG);
      step();
      chk("t5_ack_feed_idx", {o_ack_feed, o_ack_index}, {2'd1, 12'h123});
      chk("final_counts", {fail_pulses[15:0], dump_pulses[15:0]}, {16'd2, 16'd3});

      // Turn 5: asynchronous reset in WAIT_DATA
      ack_now();
      chk("t5_wait", 32'(o_state), 32'd2);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_outs", 32'(all_outs()), 32'h0);
      step();
      rst_n = 1'b1;
      step();
      chk("post_reset_send_ack", {o_state, o_ack_feed, o_ack_index}, {3'd1, 2'd0, 12'h000});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
